// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port data RAM between
// the CPU data port (master 0) and the DMA/loader port (master 1).
// An optional lock lets the current owner keep the RAM for a burst. While the
// other master is waiting, a burst is capped at MAX_BURST accesses.
module ram_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic        m0_lock,
    input  logic        m1_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);

    state_t     state_q, state_d;
    logic       last_q, last_d;      // master served most recently
    logic [7:0] bcnt_q, bcnt_d;      // consecutive accesses retained by owner
    logic [8:0] bcnt_inc;            // bcnt + 1 without wrap, for the limit test
    logic       limit_hit;
    logic       retained;

    // The grant is purely a decode of the registered state.
    assign m0_gnt = (state_q == GNT0);
    assign m1_gnt = (state_q == GNT1);

    assign m0_ack = m0_gnt & m0_req;
    assign m1_ack = m1_gnt & m1_req;

    // Read data is steered only to the owner; the other master sees zero.
    assign m0_rdata = m0_gnt ? ram_dout : 32'd0;
    assign m1_rdata = m1_gnt ? ram_dout : 32'd0;

    assign bcnt_inc  = {1'b0, bcnt_q} + 9'd1;
    assign limit_hit = (bcnt_inc >= BURST_LIMIT);

    // RAM port mux: the owner drives the RAM, everything is zero when idle.
    // A write needs an active request so a dropped req never commits.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = 32'd0;
        ram_din  = 32'd0;
        if (m0_gnt) begin
            ram_we   = m0_we & m0_req;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end else if (m1_gnt) begin
            ram_we   = m1_we & m1_req;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
    end

    // Next-owner decision from the current requests, lock and burst count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    // Tie goes to whichever master was not served last.
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_req) begin
                    state_d = GNT0;
                end else if (m1_req) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (m1_req) begin
                    // Keep the RAM only for a locked, still-requesting owner
                    // that has not yet used up its burst allowance.
                    if (m0_req && m0_lock && !limit_hit) state_d = GNT0;
                    else                                 state_d = GNT1;
                end else begin
                    state_d = m0_req ? GNT0 : IDLE;
                end
            end
            GNT1: begin
                if (m0_req) begin
                    if (m1_req && m1_lock && !limit_hit) state_d = GNT1;
                    else                                 state_d = GNT0;
                end else begin
                    state_d = m1_req ? GNT1 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bookkeeping for fairness: who was served last and how long the burst is.
    always_comb begin
        last_d = last_q;
        if (m0_ack)      last_d = 1'b0;
        else if (m1_ack) last_d = 1'b1;

        retained = (state_q != IDLE) && (state_d == state_q);
        bcnt_d   = 8'd0;
        if (retained) begin
            if (m0_ack || m1_ack) bcnt_d = (bcnt_q == 8'hFF) ? bcnt_q : bcnt_q + 8'd1;
            else                  bcnt_d = bcnt_q;
        end
    end

    // State registers; reset forces IDLE at once so any write is cut off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            bcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus a randomized run checked against a
// cycle-level model of "who owns the RAM and for how many accesses so far".
module tb_ram_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack, m0_gnt, m1_gnt, ram_we;
    logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_din, ram_dout;

    logic [31:0] mem [0:255] = '{default: 32'h0};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Single-port RAM: combinational read, write on the rising edge.
    assign ram_dout = mem[ram_addr[9:2]];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[9:2]] <= ram_din;
    end

    ram_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_we(m0_we), .m1_we(m1_we),
        .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    task automatic set_idle();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_lock = 0; m1_lock = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        set_idle();
        #1 rst = 1;
        m0_req = 1; m0_addr = 32'h100; m0_wdata = 32'h55;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({m0_gnt, m1_gnt, m0_ack, m1_ack, ram_we} !== 5'b0 || ram_addr !== 32'd0 ||
            ram_din !== 32'd0 || m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: gnt/ack/we=%b addr=%h din=%h rd0=%h rd1=%h, required all zero",
                     {m0_gnt, m1_gnt, m0_ack, m1_ack, ram_we}, ram_addr, ram_din, m0_rdata, m1_rdata);
        end
        rst = 0;
        @(negedge clk);
        n_cmp++;
        if ({m0_gnt, m0_ack, m1_gnt} !== 3'b110) begin
            n_err++;
            $display("FAIL reset_first_grant: m0_gnt,m0_ack,m1_gnt=%b required 110", {m0_gnt, m0_ack, m1_gnt});
        end
        n_cmp++;
        if (ram_addr !== 32'h100) begin
            n_err++;
            $display("FAIL reset_first_addr: ram_addr=%h required 00000100", ram_addr);
        end
        $display("reset: grant after release checked");
    endtask

    task automatic test_write_read();
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++;
        if (ram_we !== 1'b0 || m1_ack !== 1'b0) begin
            n_err++;
            $display("FAIL wr_idle_cycle: ram_we=%b m1_ack=%b required 0 0", ram_we, m1_ack);
        end
        @(negedge clk);
        n_cmp++;
        if ({m1_ack, ram_we} !== 2'b11 || ram_addr !== 32'h40 || ram_din !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wr_cycle: ack,we=%b addr=%h din=%h required 11 00000040 deadbeef",
                     {m1_ack, ram_we}, ram_addr, ram_din);
        end
        @(posedge clk); #1;
        m1_we = 0;
        @(negedge clk);
        n_cmp++;
        if ({m1_ack, ram_we} !== 2'b10 || m1_rdata !== 32'hDEADBEEF || m0_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL rd_cycle: ack,we=%b m1_rdata=%h m0_rdata=%h required 10 deadbeef 00000000",
                     {m1_ack, ram_we}, m1_rdata, m0_rdata);
        end
        $display("write_read: m1 write then read of 0x40 checked");
        set_idle();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ack;
        logic [31:0] exp_addr;
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h20;
        @(negedge clk);
        n_cmp++;
        if ({m1_ack, m0_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL rr_idle: acks=%b required 00", {m1_ack, m0_ack});
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_ack  = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (c % 2 == 0) ? 32'h10 : 32'h20;
            n_cmp++;
            if ({m1_ack, m0_ack} !== exp_ack || ram_addr !== exp_addr) begin
                n_err++;
                $display("FAIL rr_cycle%0d: acks=%b addr=%h required %b %h",
                         c, {m1_ack, m0_ack}, ram_addr, exp_ack, exp_addr);
            end
            $display("round_robin: cycle %0d acks(m1,m0)=%b", c, {m1_ack, m0_ack});
        end
        set_idle();
    endtask

    task automatic test_burst();
        logic [1:0] exp_ack;
        do_reset();
        m0_req = 1; m0_lock = 1; m1_req = 1; m0_addr = 32'h30; m1_addr = 32'h34;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 0)                exp_ack = 2'b00;
            else if ((c - 1) % 5 < MB) exp_ack = 2'b01;
            else                       exp_ack = 2'b10;
            n_cmp++;
            if ({m1_ack, m0_ack} !== exp_ack) begin
                n_err++;
                $display("FAIL burst_cycle%0d: acks=%b required %b", c, {m1_ack, m0_ack}, exp_ack);
            end
            $display("burst: cycle %0d acks(m1,m0)=%b", c, {m1_ack, m0_ack});
        end
        set_idle();
    endtask

    task automatic test_drop_req();
        logic [31:0] pre;
        do_reset();
        pre = mem[32];
        m0_req = 1; m0_we = 1; m0_addr = 32'h80; m0_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        m0_req = 0; m1_req = 1; m1_addr = 32'h84;
        @(negedge clk);
        n_cmp++;
        if ({m0_gnt, m0_ack, ram_we} !== 3'b100) begin
            n_err++;
            $display("FAIL drop_grant_cycle: gnt,ack,we=%b required 100", {m0_gnt, m0_ack, ram_we});
        end
        @(negedge clk);
        n_cmp++;
        if ({m1_gnt, m0_gnt} !== 2'b10 || mem[32] !== pre) begin
            n_err++;
            $display("FAIL drop_next: gnt(m1,m0)=%b mem=%h required 10 %h", {m1_gnt, m0_gnt}, mem[32], pre);
        end
        $display("drop_req: m0 dropped req while granted, m1 took over");
        set_idle();
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] pre;
        do_reset();
        pre = mem[48];
        m1_req = 1; m1_we = 1; m1_addr = 32'hC0; m1_wdata = 32'h12345678;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (ram_we !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_setup: ram_we=%b required 1", ram_we);
        end
        #1 rst = 1;
        #1;
        n_cmp++;
        if ({ram_we, m1_gnt, m1_ack} !== 3'b000) begin
            n_err++;
            $display("FAIL midrst_drop: we,gnt,ack=%b required 000", {ram_we, m1_gnt, m1_ack});
        end
        @(posedge clk); #1;
        n_cmp++;
        if (mem[48] !== pre) begin
            n_err++;
            $display("FAIL midrst_mem: mem=%h required %h", mem[48], pre);
        end
        $display("reset_mid_write: write suppressed");
        set_idle();
        rst = 0;
    endtask

    task automatic test_random();
        int          cur;       // current owner: -1 none, 0 or 1
        int          served;    // accesses already made in the current tenure
        int          nxt;
        logic        last;
        logic        g0, g1, a0, a1, own_req, oth_req, own_lock, exp_we;
        logic [31:0] exp_addr, exp_din, exp_rd0, exp_rd1;
        do_reset();
        cur = -1; served = 0; last = 1'b1;
        for (int c = 0; c < 600; c++) begin
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 3) != 0);
            m0_we    = 1'($urandom_range(0, 1));
            m1_we    = 1'($urandom_range(0, 1));
            m0_lock  = ($urandom_range(0, 3) != 0);
            m1_lock  = ($urandom_range(0, 3) != 0);
            m0_addr  = $urandom; m1_addr  = $urandom;
            m0_wdata = $urandom; m1_wdata = $urandom;
            @(negedge clk);
            g0 = (cur == 0); g1 = (cur == 1);
            a0 = g0 && m0_req; a1 = g1 && m1_req;
            exp_we   = g0 ? (m0_we && m0_req) : (g1 ? (m1_we && m1_req) : 1'b0);
            exp_addr = g0 ? m0_addr  : (g1 ? m1_addr  : 32'd0);
            exp_din  = g0 ? m0_wdata : (g1 ? m1_wdata : 32'd0);
            exp_rd0  = g0 ? mem[m0_addr[9:2]] : 32'd0;
            exp_rd1  = g1 ? mem[m1_addr[9:2]] : 32'd0;
            n_cmp++;
            if ({m0_gnt, m1_gnt, m0_ack, m1_ack} !== {g0, g1, a0, a1}) begin
                n_err++;
                $display("FAIL rnd%0d_grant: gnt0,gnt1,ack0,ack1=%b required %b",
                         c, {m0_gnt, m1_gnt, m0_ack, m1_ack}, {g0, g1, a0, a1});
            end
            n_cmp++;
            if (ram_we !== exp_we || ram_addr !== exp_addr || ram_din !== exp_din) begin
                n_err++;
                $display("FAIL rnd%0d_ram: we=%b addr=%h din=%h required %b %h %h",
                         c, ram_we, ram_addr, ram_din, exp_we, exp_addr, exp_din);
            end
            n_cmp++;
            if (m0_rdata !== exp_rd0 || m1_rdata !== exp_rd1) begin
                n_err++;
                $display("FAIL rnd%0d_rdata: rd0=%h rd1=%h required %h %h", c, m0_rdata, m1_rdata, exp_rd0, exp_rd1);
            end
            $display("random: cycle %0d owner=%0d req=%b%b acks=%b%b", c, cur, m1_req, m0_req, a1, a0);
            // Decide who owns the RAM next cycle.
            if (cur < 0) begin
                if (m0_req && m1_req) nxt = last ? 0 : 1;
                else if (m0_req)      nxt = 0;
                else if (m1_req)      nxt = 1;
                else                  nxt = -1;
            end else begin
                own_req  = (cur == 0) ? m0_req  : m1_req;
                oth_req  = (cur == 0) ? m1_req  : m0_req;
                own_lock = (cur == 0) ? m0_lock : m1_lock;
                if (!own_req)                                         nxt = oth_req ? 1 - cur : -1;
                else if (oth_req && (!own_lock || served + 1 >= MB))  nxt = 1 - cur;
                else                                                  nxt = cur;
            end
            if (a0) last = 1'b0;
            if (a1) last = 1'b1;
            served = (cur >= 0 && nxt == cur) ? served + 1 : 0;
            cur = nxt;
            @(posedge clk); #1;
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_write_read();
        test_round_robin();
        test_burst();
        test_drop_req();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter that shares the single-port data RAM (word-addressed, combinational read, write on rising edge) between the CPU data port (master 0) and the DMA/loader port (master 1). It sits directly in front of the RAM, owns the RAM's `we`/`addr`/`d_in` inputs, and returns RAM `d_out` to the granted master. Arbitration is round-robin with an optional lock for bursts, bounded by a burst limit so that neither master starves.

## Interface
- `MAX_BURST`, 8: maximum consecutive locked grants to one master while the other is requesting; range 1..255.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  access request; held until `ack`.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_lock`, `m1_lock`  in  1  request to keep the grant after the current access.
- `m0_addr`, `m1_addr`  in  32  byte address; the RAM uses bits [31:2].
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_ack`, `m1_ack`  out  1  access performed this cycle.
- `m0_rdata`, `m1_rdata`  out  32  read data, valid when `ack` = 1.
- `m0_gnt`, `m1_gnt`  out  1  registered grant (state indicator).
- `ram_we`  out  1  to RAM `we`.
- `ram_addr`  out  32  to RAM `addr`.
- `ram_din`  out  32  to RAM `d_in`.
- `ram_dout`  in  32  from RAM `d_out`.

## Operation
- States: IDLE, GNT0, GNT1. The state register is the only grant source; `mX_gnt` = (state == GNTX).
- Registers: `state`, `last` (last master served), `bcnt` (8-bit consecutive-grant count).
- Reset: state=IDLE, `last`=1 (master 0 wins the first tie), `bcnt`=0. All outputs are 0 during and after reset until a grant exists.
- RAM mux, combinational: in GNTx, `ram_addr`=mX_addr, `ram_din`=mX_wdata, `ram_we`=mX_we & mX_req; otherwise all three are 0.
- `mX_ack` = mX_gnt & mX_req. `mX_rdata` = mX_gnt ? ram_dout : 0.
- Next-state decision, evaluated every cycle on current requests:
  - IDLE: if one master requests, grant it. If both request, grant the master != `last`. If none request, stay in IDLE.
  - GNTx, other master requesting, and either `mX_lock`=0 or `bcnt`+1 >= MAX_BURST: switch to the other master.
  - GNTx, other master requesting, `mX_lock`=1, and `bcnt`+1 < MAX_BURST: stay in GNTx if mX_req, else switch.
  - GNTx, other master idle: stay in GNTx if mX_req, else go to IDLE.
- `last` is loaded with X on every cycle that mX_ack=1.
- `bcnt`: increments (saturating at 255) on each acked cycle in which the grant is retained. It clears on any grant change or on IDLE.
- A master that drops `req` while granted causes no RAM write and no ack. Address and data changes during a grant take effect the same cycle.

## Timing
- Grant latency: `req` seen in cycle N while IDLE → GNT from edge N+1. The access, `ack`, and `rdata` occur in cycle N+1. A write commits to the RAM at the end of N+1.
- Back-to-back: a master holding `req` with the other idle gets one access per cycle after the first.
- Both continuously requesting, no lock: grants alternate every cycle (0,1,0,1…).
- With lock: at most MAX_BURST consecutive accesses while the other master waits, then a forced switch. The other master waits at most MAX_BURST+1 cycles.
- Simultaneous first request from IDLE after reset: master 0 wins.
- Reset mid-grant: the state goes to IDLE immediately (asynchronous). `ram_we` drops at once, so no write commits on the next edge.
- The arbiter adds no combinational path from `ram_dout` to any RAM input.

## Test plan
- Reset with `m0_req`=1 held → all outputs 0 during reset. After release: `m0_gnt`=1 one cycle later, `m0_ack`=1, `ram_addr`=m0_addr.
- m1 writes 0xDEADBEEF to addr 0x40, then reads addr 0x40 → read `ack` cycle shows `m1_rdata`=0xDEADBEEF. `ram_we` is high only in the write ack cycle.
- Both masters request from IDLE, no lock, for 6 cycles → ack sequence m0,m1,m0,m1,m0,m1.
- MAX_BURST=4, m0 lock=1 with continuous req, m1 req from cycle 0 → m0 acked 4 times, then m1 acked; `bcnt` returns to 0 at the switch.
- m0 granted, drops `req` in the grant cycle → `ram_we`=0, `m0_ack`=0, and the next state is IDLE (or GNT1 if m1 is requesting).
- Assert `rst` in the middle of an m1 write cycle → `ram_we` is 0 at the following edge and the RAM word is unchanged.
